// File: rtl/bcd_tick_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : bcd_tick_counter                                            |
// | Description: Prescaled up/down packed-BCD counter with synchronous       |
// |              clear/load, roll-over pulse and active-low 7-segment        |
// |              outputs with optional leading-zero blanking.                |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module bcd_tick_counter #(
  parameter int CLK_FREQ = 50000000,
  parameter int TICK_HZ  = 1,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   HEX,
  output logic                  tick,
  output logic                  wrap
);

  localparam int             DIV       = CLK_FREQ / TICK_HZ;
  localparam int             PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);

  logic [PW-1:0]          presc;
  logic [4*DIGITS-1:0]    count_step;
  logic [4*DIGITS-1:0]    load_sat;
  logic                   roll;
  logic [3:0]             step_digit;
  logic [3:0]             hex_digit;
  logic                   hi_zero;

  // Active-low gfedcba segment pattern for one BCD digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h18;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Count advances on the last prescaler cycle; gated by en so a held
  // prescaler parked at its terminal value does not keep firing.
  assign tick = en && (presc == PRESC_MAX);

  // Loaded digits above 9 are clamped so the count is always legal BCD.
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_load_sat
      assign load_sat[4*g +: 4] = (load_val[4*g +: 4] > 4'd9) ? 4'd9 : load_val[4*g +: 4];
    end
  endgenerate

  // Ripple carry/borrow across digits; roll left set means every digit wrapped.
  always_comb begin
    count_step = count;
    roll       = 1'b1;
    step_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      step_digit = count[4*i +: 4];
      if (roll) begin
        if (up) begin
          if (step_digit == 4'd9) begin
            count_step[4*i +: 4] = 4'd0;
          end else begin
            count_step[4*i +: 4] = step_digit + 4'd1;
            roll                 = 1'b0;
          end
        end else begin
          if (step_digit == 4'd0) begin
            count_step[4*i +: 4] = 4'd9;
          end else begin
            count_step[4*i +: 4] = step_digit - 4'd1;
            roll                 = 1'b0;
          end
        end
      end
    end
  end

  // Prescaler, count and wrap pulse; clear beats load beats tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      count <= '0;
      wrap  <= 1'b0;
    end else if (clr) begin
      presc <= '0;
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      presc <= '0;
      count <= load_sat;
      wrap  <= 1'b0;
    end else begin
      wrap <= tick && roll;
      if (tick) begin
        presc <= '0;
        count <= count_step;
      end else if (en) begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Segment decode from the top digit down so leading zeros can be tracked.
  always_comb begin
    HEX       = '1;
    hi_zero   = 1'b1;
    hex_digit = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hex_digit = count[4*i +: 4];
      hi_zero   = hi_zero && (hex_digit == 4'd0);
      if (blank_lz && (i != 0) && hi_zero) begin
        HEX[7*i +: 7] = 7'h7F;
      end else begin
        HEX[7*i +: 7] = seg7(hex_digit);
      end
    end
  end

endmodule
`default_nettype wire
